// File: rtl/cpu_datapath.sv
// Single-bus datapath for the course RISC CPU: register file, special registers,
// 64-bit ALU result register, I/O ports, CON flip-flop and a word-addressed RAM.
module cpu_datapath #(
    parameter int MEM_DEPTH = 512,
    parameter int WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         HIin,
    input  logic                         Loin,
    input  logic                         ZHIin,
    input  logic                         ZLOin,
    input  logic                         Zin,
    input  logic                         PCin,
    input  logic                         MDRin,
    input  logic                         MARin,
    input  logic                         IRin,
    input  logic                         Yin,
    input  logic                         OPin,
    input  logic                         HIout,
    input  logic                         Loout,
    input  logic                         ZHIout,
    input  logic                         ZLOout,
    input  logic                         ZLowSelect,
    input  logic                         ZHighSelect,
    input  logic                         PCout,
    input  logic                         MDRout,
    input  logic                         MARout,
    input  logic                         Yout,
    input  logic                         IRout,
    input  logic                         InPortout,
    input  logic                         Cout,
    input  logic                         MDRread,
    input  logic                         IncPC,
    input  logic                         Gra,
    input  logic                         Grb,
    input  logic                         Grc,
    input  logic                         Rin,
    input  logic                         Rout,
    input  logic                         BAout,
    input  logic                         CON_FF_In,
    input  logic                         wren,
    input  logic [4:0]                   ALUSelection,
    input  logic [WIDTH-1:0]             in_32,
    output logic                         CON_FF_Out,
    output logic [WIDTH-1:0]             R0,
    output logic [WIDTH-1:0]             R1,
    output logic [WIDTH-1:0]             R2,
    output logic [WIDTH-1:0]             R3,
    output logic [WIDTH-1:0]             R4,
    output logic [WIDTH-1:0]             R5,
    output logic [WIDTH-1:0]             R6,
    output logic [WIDTH-1:0]             R7,
    output logic [WIDTH-1:0]             R8,
    output logic [WIDTH-1:0]             R9,
    output logic [WIDTH-1:0]             R10,
    output logic [WIDTH-1:0]             R11,
    output logic [WIDTH-1:0]             R12,
    output logic [15:0]                  R13,
    output logic [15:0]                  R14,
    output logic [WIDTH-1:0]             R15,
    output logic [WIDTH-1:0]             HI,
    output logic [WIDTH-1:0]             LO,
    output logic [WIDTH-1:0]             Y,
    output logic [WIDTH-1:0]             ZLO,
    output logic [WIDTH-1:0]             ZHI,
    output logic [WIDTH-1:0]             IR,
    output logic [WIDTH-1:0]             INPORT,
    output logic [WIDTH-1:0]             OUTPORT,
    output logic [$clog2(MEM_DEPTH)-1:0] MAR,
    output logic [2*WIDTH-1:0]           Z_register
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [4:0] {
        ALU_PASS = 5'b00000,
        ALU_ADD  = 5'b00001,
        ALU_SUB  = 5'b00010,
        ALU_AND  = 5'b00011,
        ALU_OR   = 5'b00100,
        ALU_SHR  = 5'b00101,
        ALU_SHRA = 5'b00110,
        ALU_SHL  = 5'b00111,
        ALU_ROR  = 5'b01000,
        ALU_ROL  = 5'b01001,
        ALU_MUL  = 5'b01010,
        ALU_DIV  = 5'b01011,
        ALU_NEG  = 5'b01100,
        ALU_NOT  = 5'b01101
    } alu_op_e;

    logic [WIDTH-1:0]   r_gpr [16];
    logic [WIDTH-1:0]   r_pc, r_ir, r_mdr, r_hi, r_lo, r_y, r_inport, r_outport;
    logic [AW-1:0]      r_mar;
    logic [2*WIDTH-1:0] r_z;
    logic               r_con;
    logic [WIDTH-1:0]   r_ram [MEM_DEPTH];

    logic [WIDTH-1:0]   w_bus, w_c, w_ram_rd;
    logic [3:0]         w_sel;
    logic [2*WIDTH-1:0] w_alu, w_ror_full, w_rol_full, w_prod;
    logic [SW-1:0]      w_sh;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic               w_cond;

    assign w_sel = ({4{Gra}} & r_ir[26:23]) | ({4{Grb}} & r_ir[22:19]) | ({4{Grc}} & r_ir[18:15]);
    assign w_c   = {{(WIDTH-19){r_ir[18]}}, r_ir[18:0]};
    assign w_ram_rd = r_ram[r_mar];

    // Priority chain only matters when the controller misbehaves; normally one source is on.
    always_comb begin
        w_bus = '0;
        if (Rout)                       w_bus = r_gpr[w_sel];
        else if (BAout)                 w_bus = (w_sel == 4'd0) ? '0 : r_gpr[w_sel];
        else if (HIout)                 w_bus = r_hi;
        else if (Loout)                 w_bus = r_lo;
        else if (ZHIout || ZHighSelect) w_bus = r_z[2*WIDTH-1:WIDTH];
        else if (ZLOout || ZLowSelect)  w_bus = r_z[WIDTH-1:0];
        else if (PCout)                 w_bus = r_pc;
        else if (MDRout)                w_bus = r_mdr;
        else if (InPortout)             w_bus = r_inport;
        else if (Cout)                  w_bus = w_c;
        else if (Yout)                  w_bus = r_y;
        else if (MARout)                w_bus = WIDTH'(r_mar);
        else if (IRout)                 w_bus = r_ir;
    end

    assign w_sh       = w_bus[SW-1:0];
    assign w_ror_full = {r_y, r_y} >> w_sh;
    assign w_rol_full = {r_y, r_y} << w_sh;
    assign w_prod     = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y}) * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});
    assign w_quot     = (w_bus == '0) ? '1  : WIDTH'($signed(r_y) / $signed(w_bus));
    assign w_rem      = (w_bus == '0) ? r_y : WIDTH'($signed(r_y) % $signed(w_bus));

    always_comb begin
        w_alu = '0;
        if (IncPC) begin
            w_alu[WIDTH-1:0] = w_bus + 1'b1;
        end else begin
            case (alu_op_e'(ALUSelection))
                ALU_PASS: w_alu[WIDTH-1:0] = w_bus;
                ALU_ADD:  w_alu[WIDTH-1:0] = r_y + w_bus;
                ALU_SUB:  w_alu[WIDTH-1:0] = r_y - w_bus;
                ALU_AND:  w_alu[WIDTH-1:0] = r_y & w_bus;
                ALU_OR:   w_alu[WIDTH-1:0] = r_y | w_bus;
                ALU_SHR:  w_alu[WIDTH-1:0] = r_y >> w_sh;
                ALU_SHRA: w_alu[WIDTH-1:0] = WIDTH'($signed(r_y) >>> w_sh);
                ALU_SHL:  w_alu[WIDTH-1:0] = r_y << w_sh;
                ALU_ROR:  w_alu[WIDTH-1:0] = w_ror_full[WIDTH-1:0];
                ALU_ROL:  w_alu[WIDTH-1:0] = w_rol_full[2*WIDTH-1:WIDTH];
                ALU_MUL:  w_alu = w_prod;
                ALU_DIV:  w_alu = {w_rem, w_quot};
                ALU_NEG:  w_alu[WIDTH-1:0] = '0 - w_bus;
                ALU_NOT:  w_alu[WIDTH-1:0] = ~w_bus;
                default:  w_alu = '0;
            endcase
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_ir[20:19])
            2'b00: w_cond = (w_bus == '0);
            2'b01: w_cond = (w_bus != '0);
            2'b10: w_cond = ~w_bus[WIDTH-1];
            2'b11: w_cond = w_bus[WIDTH-1];
            default: w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int unsigned i = 0; i < 16; i++) r_gpr[i] <= '0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_y       <= '0;
            r_inport  <= '0;
            r_outport <= '0;
            r_mar     <= '0;
            r_z       <= '0;
            r_con     <= 1'b0;
        end else begin
            r_inport <= in_32;
            if (Rin)       r_gpr[w_sel] <= w_bus;
            if (PCin)      r_pc         <= w_bus;
            if (IRin)      r_ir         <= w_bus;
            if (MDRin)     r_mdr        <= MDRread ? w_ram_rd : w_bus;
            if (HIin)      r_hi         <= w_bus;
            if (Loin)      r_lo         <= w_bus;
            if (Yin)       r_y          <= w_bus;
            if (OPin)      r_outport    <= w_bus;
            if (MARin)     r_mar        <= w_bus[AW-1:0];
            if (CON_FF_In) r_con        <= w_cond;
            if (Zin) begin
                r_z <= w_alu;
            end else begin
                if (ZLOin) r_z[WIDTH-1:0]         <= w_alu[WIDTH-1:0];
                if (ZHIin) r_z[2*WIDTH-1:WIDTH]   <= w_alu[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wren) r_ram[r_mar] <= r_mdr;
    end

    assign R0  = r_gpr[0];
    assign R1  = r_gpr[1];
    assign R2  = r_gpr[2];
    assign R3  = r_gpr[3];
    assign R4  = r_gpr[4];
    assign R5  = r_gpr[5];
    assign R6  = r_gpr[6];
    assign R7  = r_gpr[7];
    assign R8  = r_gpr[8];
    assign R9  = r_gpr[9];
    assign R10 = r_gpr[10];
    assign R11 = r_gpr[11];
    assign R12 = r_gpr[12];
    assign R13 = r_gpr[13][15:0];
    assign R14 = r_gpr[14][15:0];
    assign R15 = r_gpr[15];

    assign HI         = r_hi;
    assign LO         = r_lo;
    assign Y          = r_y;
    assign ZLO        = r_z[WIDTH-1:0];
    assign ZHI        = r_z[2*WIDTH-1:WIDTH];
    assign IR         = r_ir;
    assign INPORT     = r_inport;
    assign OUTPORT    = r_outport;
    assign MAR        = r_mar;
    assign Z_register = r_z;
    assign CON_FF_Out = r_con;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: control strobes driven by hand, ALU checked from a vector table.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic        HIin, Loin, ZHIin, ZLOin, Zin, PCin, MDRin, MARin, IRin, Yin, OPin;
    logic        HIout, Loout, ZHIout, ZLOout, ZLowSelect, ZHighSelect, PCout, MDRout;
    logic        MARout, Yout, IRout, InPortout, Cout, MDRread, IncPC;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren;
    logic [4:0]  ALUSelection;
    logic [31:0] in_32;

    logic        CON_FF_Out;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R15;
    logic [15:0] R13, R14;
    logic [31:0] HI, LO, Y, ZLO, ZHI, IR, INPORT, OUTPORT;
    logic [8:0]  MAR;
    logic [63:0] Z_register;

    int n_vec;
    int n_bad;

    cpu_datapath #(.MEM_DEPTH(512), .WIDTH(32)) dut (
        .clk(clk), .clr(clr),
        .HIin(HIin), .Loin(Loin), .ZHIin(ZHIin), .ZLOin(ZLOin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin), .OPin(OPin),
        .HIout(HIout), .Loout(Loout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .PCout(PCout), .MDRout(MDRout),
        .MARout(MARout), .Yout(Yout), .IRout(IRout), .InPortout(InPortout), .Cout(Cout),
        .MDRread(MDRread), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .CON_FF_In(CON_FF_In), .wren(wren),
        .ALUSelection(ALUSelection), .in_32(in_32), .CON_FF_Out(CON_FF_Out),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14), .R15(R15),
        .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .IR(IR), .INPORT(INPORT),
        .OUTPORT(OUTPORT), .MAR(MAR), .Z_register(Z_register)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_z;
    } alu_vec_t;

    task automatic idle();
        {HIin, Loin, ZHIin, ZLOin, Zin, PCin, MDRin, MARin, IRin, Yin, OPin} = '0;
        {HIout, Loout, ZHIout, ZLOout, ZLowSelect, ZHighSelect, PCout, MDRout} = '0;
        {MARout, Yout, IRout, InPortout, Cout, MDRread, IncPC} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In, wren} = '0;
        ALUSelection = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        idle();
    endtask

    // INPORT samples in_32 every edge, so the value is on the bus one cycle later.
    task automatic feed(input logic [31:0] v);
        in_32 = v;
        tick();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        alu_vec_t vecs[$];
        n_vec = 0;
        n_bad = 0;
        idle();
        in_32 = '0;
        clr   = 1'b1;

        vecs.push_back('{"pass",   5'b00000, 32'h12345678, 32'hCAFEF00D, 64'h00000000CAFEF00D});
        vecs.push_back('{"add",    5'b00001, 32'hFFFFFFFF, 32'h00000002, 64'h0000000000000001});
        vecs.push_back('{"sub",    5'b00010, 32'h00000005, 32'h00000007, 64'h00000000FFFFFFFE});
        vecs.push_back('{"and",    5'b00011, 32'hF0F0F0F0, 32'h3C3C3C3C, 64'h0000000030303030});
        vecs.push_back('{"or",     5'b00100, 32'hF0F0F0F0, 32'h3C3C3C3C, 64'h00000000FCFCFCFC});
        vecs.push_back('{"shr",    5'b00101, 32'h80000010, 32'h00000004, 64'h0000000008000001});
        vecs.push_back('{"shra",   5'b00110, 32'h80000010, 32'h00000004, 64'h00000000F8000001});
        vecs.push_back('{"shl",    5'b00111, 32'h80000010, 32'h00000024, 64'h0000000000000100});
        vecs.push_back('{"ror",    5'b01000, 32'h12345678, 32'h00000008, 64'h0000000078123456});
        vecs.push_back('{"rol",    5'b01001, 32'h12345678, 32'h00000008, 64'h0000000034567812});
        vecs.push_back('{"mul_neg",5'b01010, 32'hFFFFFFFA, 32'h00000004, 64'hFFFFFFFFFFFFFFE8});
        vecs.push_back('{"mul_big",5'b01010, 32'h00010000, 32'h00010000, 64'h0000000100000000});
        vecs.push_back('{"div",    5'b01011, 32'h00000011, 32'h00000005, 64'h0000000200000003});
        vecs.push_back('{"div_neg",5'b01011, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFFFFFFFFFD});
        vecs.push_back('{"div_0",  5'b01011, 32'h00000011, 32'h00000000, 64'h00000011FFFFFFFF});
        vecs.push_back('{"neg",    5'b01100, 32'h00000009, 32'h00000001, 64'h00000000FFFFFFFF});
        vecs.push_back('{"not",    5'b01101, 32'h00000009, 32'h0000FFFF, 64'h00000000FFFF0000});
        vecs.push_back('{"bad_op", 5'b01110, 32'h00000001, 32'h00000001, 64'h0000000000000000});
        vecs.push_back('{"bad_op2",5'b11111, 32'h00000001, 32'h00000001, 64'h0000000000000000});

        #2 clr = 1'b0;
        repeat (3) tick();
        chk("rst_R0", 64'(R0), 64'h0);
        chk("rst_R13", 64'(R13), 64'h0);
        chk("rst_R15", 64'(R15), 64'h0);
        chk("rst_HI_LO", {HI, LO}, 64'h0);
        chk("rst_Y", 64'(Y), 64'h0);
        chk("rst_IR", 64'(IR), 64'h0);
        chk("rst_Z", Z_register, 64'h0);
        chk("rst_MAR", 64'(MAR), 64'h0);
        chk("rst_ports", {INPORT, OUTPORT}, 64'h0);
        chk("rst_CON", 64'(CON_FF_Out), 64'h0);
        clr = 1'b1;

        feed(32'h01000044); InPortout = 1; IRin = 1; step();
        chk("fetch_IR", 64'(IR), 64'h01000044);
        InPortout = 1; Yin = 1; step();
        chk("inport_Y", 64'(Y), 64'h01000044);
        InPortout = 1; Grb = 1; Rin = 1; step();
        chk("write_R0", 64'(R0), 64'h01000044);
        Grb = 1; BAout = 1; Yin = 1; step();
        chk("baout_R0_zero", 64'(Y), 64'h0);
        Cout = 1; Zin = 1; ALUSelection = 5'b00001; step();
        chk("c_add_Z", Z_register, 64'h44);
        ZLOout = 1; MARin = 1; step();
        chk("mar_load", 64'(MAR), 64'h044);

        feed(32'hDEADBEEF); InPortout = 1; MDRin = 1; step();
        wren = 1; step();
        feed(32'h0); InPortout = 1; MDRin = 1; step();
        MDRread = 1; MDRin = 1; step();
        Gra = 1; MDRout = 1; Rin = 1; step();
        chk("ram_to_R2", 64'(R2), 64'hDEADBEEF);

        feed(32'h55555555); Gra = 1; Rout = 1; InPortout = 1; Yin = 1; step();
        chk("bus_priority", 64'(Y), 64'hDEADBEEF);
        Gra = 1; BAout = 1; OPin = 1; step();
        chk("outport", 64'(OUTPORT), 64'hDEADBEEF);
        Yin = 1; step();
        chk("bus_idle_zero", 64'(Y), 64'h0);
        MARout = 1; Yin = 1; step();
        chk("mar_on_bus", 64'(Y), 64'h44);

        feed(32'd5); InPortout = 1; PCin = 1; step();
        PCout = 1; IncPC = 1; ALUSelection = 5'b00010; Zin = 1; step();
        chk("incpc_Z", Z_register, 64'd6);
        ZLOout = 1; PCin = 1; step();
        PCout = 1; Yin = 1; step();
        chk("pc_after_inc", 64'(Y), 64'd6);

        foreach (vecs[i]) begin
            feed(vecs[i].a); InPortout = 1; Yin = 1; step();
            feed(vecs[i].b); InPortout = 1; ALUSelection = vecs[i].op; Zin = 1; step();
            chk({"alu_", vecs[i].name}, Z_register, vecs[i].exp_z);
        end

        feed(32'd17); InPortout = 1; Yin = 1; step();
        feed(32'd5); InPortout = 1; ALUSelection = 5'b01011; Zin = 1; step();
        ZHIout = 1; HIin = 1; step();
        chk("div_HI", 64'(HI), 64'd2);
        ZLowSelect = 1; Loin = 1; step();
        chk("div_LO", 64'(LO), 64'd3);
        feed(32'hAAAA5555); InPortout = 1; ZLOin = 1; step();
        chk("zlo_only", Z_register, 64'h00000002AAAA5555);
        feed(32'h0); InPortout = 1; ALUSelection = 5'b01011; ZHIin = 1; step();
        chk("zhi_only", Z_register, 64'h00000011AAAA5555);

        feed(32'h06800000); InPortout = 1; IRin = 1; step();
        feed(32'h12345678); InPortout = 1; Gra = 1; Rin = 1; step();
        chk("R13_low_half", 64'(R13), 64'h5678);
        chk("R14_untouched", 64'(R14), 64'h0);
        Gra = 1; Rout = 1; Yin = 1; step();
        chk("R13_full_on_bus", 64'(Y), 64'h12345678);

        CON_FF_In = 1; step();
        chk("con_eq0_true", 64'(CON_FF_Out), 64'h1);
        feed(32'h1); InPortout = 1; CON_FF_In = 1; step();
        chk("con_eq0_false", 64'(CON_FF_Out), 64'h0);
        feed(32'h00180000); InPortout = 1; IRin = 1; step();
        feed(32'h80000000); InPortout = 1; CON_FF_In = 1; step();
        chk("con_neg_true", 64'(CON_FF_Out), 64'h1);
        feed(32'h7FFFFFFF); InPortout = 1; CON_FF_In = 1; step();
        chk("con_neg_false", 64'(CON_FF_Out), 64'h0);
        feed(32'h80000000); InPortout = 1; CON_FF_In = 1; step();
        #2 clr = 1'b0;
        #1;
        chk("async_clr_con", 64'(CON_FF_Out), 64'h0);
        chk("async_clr_IR", 64'(IR), 64'h0);
        chk("async_clr_R2", 64'(R2), 64'h0);
        tick();
        clr = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
